// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared types and constants for the ALU/MOV sequencing
//                controller: state encoding, opcode and ALUop codes, regfile
//                select one-hots, the strobe bundle and the DECODE dispatch.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

  localparam int PKG_STATE_W = 4;

  typedef enum logic [PKG_STATE_W-1:0] {
    S_WAIT   = 4'd0,
    S_DECODE = 4'd1,
    S_GET_A  = 4'd2,
    S_GET_B  = 4'd3,
    S_EXEC   = 4'd4,
    S_EXEC_S = 4'd5,
    S_WR_REG = 4'd6,
    S_WR_IMM = 4'd7,
    S_ILL    = 4'd8
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  // Strobe bundle driven by the state table each cycle.
  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic       vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic       write;
    logic [1:0] alu_op;
  } ctrl_t;

  // First state after DECODE for a latched opcode/op pair.
  function automatic state_e decode_next(input logic [2:0] opc, input logic [1:0] sub);
    state_e nxt;
    case ({opc, sub})
      {OPC_MOV, MOV_IMM}: nxt = S_WR_IMM;
      {OPC_MOV, MOV_REG}: nxt = S_GET_B;
      {OPC_ALU, ALU_ADD}: nxt = S_GET_A;
      {OPC_ALU, ALU_SUB}: nxt = S_GET_A;
      {OPC_ALU, ALU_AND}: nxt = S_GET_A;
      {OPC_ALU, ALU_NOT}: nxt = S_GET_B;
      default:            nxt = S_ILL;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_decode
//  Description : Combinational state-to-strobe table. Outputs depend only on
//                the current state and the fields latched at acceptance, so
//                no input-to-output combinational path exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_decode
  import alu_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [2:0] opcode_q,
  input  logic [1:0] op_q,
  output ctrl_t      ctrl
);

  logic is_mov;
  assign is_mov = (opcode_q == OPC_MOV);

  // Per-state strobe table; everything defaults low so only one load/write fires.
  always_comb begin
    ctrl = '0;
    case (state)
      S_WAIT: begin
        ctrl.w = 1'b1;
      end
      S_GET_A: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.loada = 1'b1;
      end
      S_GET_B: begin
        ctrl.nsel  = NSEL_RM;
        ctrl.loadb = 1'b1;
      end
      S_EXEC: begin
        ctrl.loadc  = 1'b1;
        // MOV reg passes B through an add with a zeroed A operand.
        ctrl.asel   = is_mov;
        ctrl.alu_op = is_mov ? ALU_ADD : op_q;
      end
      S_EXEC_S: begin
        ctrl.loads  = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      S_WR_REG: begin
        ctrl.nsel  = NSEL_RD;
        ctrl.write = 1'b1;
      end
      S_WR_IMM: begin
        ctrl.nsel  = NSEL_RN;
        ctrl.vsel  = 1'b1;
        ctrl.write = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_ctrl
//  Description : Multi-cycle Moore sequencer for ALU and MOV instructions.
//                Accepts an opcode/op pair on s while idle, then steps through
//                operand fetch, execute and writeback.
//                Optional macro ILLEGAL_TRAP_EN: illegal instructions set a
//                sticky err flag that blocks acceptance until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s,
  input  logic [2:0]         opcode,
  input  logic [1:0]         op,
  output logic               w,
  output logic [2:0]         nsel,
  output logic               vsel,
  output logic               loada,
  output logic               loadb,
  output logic               asel,
  output logic               bsel,
  output logic               loadc,
  output logic               loads,
  output logic               write,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               err
);

  logic [STATE_W-1:0] state_q;
  state_e             state;
  state_e             state_d;
  logic [2:0]         opcode_q;
  logic [1:0]         op_q;
  logic               err_q;
  logic               accept;
  ctrl_t              ctrl;

  assign state  = state_e'(state_q);
  assign accept = (state == S_WAIT) && s && !err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= STATE_W'(S_WAIT);
    else       state_q <= STATE_W'(state_d);
  end

  // Capture the instruction fields on acceptance; inputs are free afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q <= 3'b000;
      op_q     <= 2'b00;
    end else if (accept) begin
      opcode_q <= opcode;
      op_q     <= op;
    end
  end

  // Next-state logic; s is only looked at in WAIT.
  always_comb begin
    state_d = state;
    case (state)
      S_WAIT:   state_d = accept ? S_DECODE : S_WAIT;
      S_DECODE: state_d = decode_next(opcode_q, op_q);
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = ((opcode_q == OPC_ALU) && (op_q == ALU_SUB)) ? S_EXEC_S : S_EXEC;
      S_EXEC:   state_d = S_WR_REG;
      S_EXEC_S: state_d = S_WAIT;
      S_WR_REG: state_d = S_WAIT;
      S_WR_IMM: state_d = S_WAIT;
      S_ILL:    state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky trap flag, raised as the sequencer enters ILL.
  always_ff @(posedge clk) begin
    if (reset)                                        err_q <= 1'b0;
    else if ((state == S_DECODE) && (state_d == S_ILL)) err_q <= 1'b1;
  end
`else
  assign err_q = 1'b0;
`endif

  alu_seq_decode u_decode (
    .state    (state),
    .opcode_q (opcode_q),
    .op_q     (op_q),
    .ctrl     (ctrl)
  );

  assign w     = ctrl.w & ~err_q;
  assign nsel  = ctrl.nsel;
  assign vsel  = ctrl.vsel;
  assign loada = ctrl.loada;
  assign loadb = ctrl.loadb;
  assign asel  = ctrl.asel;
  assign bsel  = ctrl.bsel;
  assign loadc = ctrl.loadc;
  assign loads = ctrl.loads;
  assign write = ctrl.write;
  assign ALUop = ALUOP_W'(ctrl.alu_op);
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_ctrl
//  Description : Directed scoreboard bench for alu_seq_ctrl. Each issued
//                instruction pushes its expected per-cycle output vectors;
//                every falling edge pops one and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, vsel, loada, loadb, asel, bsel, loadc, loads, write, err;
  logic [2:0] nsel;
  logic [1:0] ALUop;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic       vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic       write;
    logic [1:0] aluop;
    logic       err;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  err_model = 1'b0;

  alu_seq_ctrl #(.STATE_W(4), .ALUOP_W(2)) dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads), .write(write),
    .ALUop(ALUop), .err(err)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t blank();
    exp_t e = '0;
    e.err = err_model;
    return e;
  endfunction

  function automatic exp_t idle();
    exp_t e = blank();
    e.w = !err_model;
    return e;
  endfunction

  task automatic push(input exp_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Reference model: expected outputs for each cycle after acceptance.
  task automatic push_seq(input logic [2:0] opc, input logic [1:0] o, input string name);
    exp_t ga, gb, ex, wr;
    logic legal_alu;
    ga = blank(); ga.nsel = 3'b001; ga.loada = 1'b1;
    gb = blank(); gb.nsel = 3'b100; gb.loadb = 1'b1;
    ex = blank(); ex.loadc = 1'b1;
    wr = blank(); wr.nsel = 3'b010; wr.write = 1'b1;
    legal_alu = (opc == 3'b101);
    push(blank(), {name, ":DECODE"});
    if (legal_alu && (o == 2'b00 || o == 2'b10)) begin
      ex.aluop = o;
      push(ga, {name, ":GET_A"}); push(gb, {name, ":GET_B"});
      push(ex, {name, ":EXEC"});  push(wr, {name, ":WR_REG"});
    end else if (legal_alu && o == 2'b01) begin
      ex = blank(); ex.loads = 1'b1; ex.aluop = 2'b01;
      push(ga, {name, ":GET_A"}); push(gb, {name, ":GET_B"});
      push(ex, {name, ":EXEC_S"});
    end else if (legal_alu && o == 2'b11) begin
      ex.aluop = 2'b11;
      push(gb, {name, ":GET_B"}); push(ex, {name, ":EXEC"});
      push(wr, {name, ":WR_REG"});
    end else if (opc == 3'b110 && o == 2'b00) begin
      ex.asel = 1'b1; ex.aluop = 2'b00;
      push(gb, {name, ":GET_B"}); push(ex, {name, ":EXEC"});
      push(wr, {name, ":WR_REG"});
    end else if (opc == 3'b110 && o == 2'b10) begin
      wr = blank(); wr.nsel = 3'b001; wr.vsel = 1'b1; wr.write = 1'b1;
      push(wr, {name, ":WR_IMM"});
    end else begin
`ifdef ILLEGAL_TRAP_EN
      err_model = 1'b1;
`endif
      push(blank(), {name, ":ILL"});
    end
    push(idle(), {name, ":WAIT"});
  endtask

  task automatic check_cycle();
    exp_t  e, obs;
    string t;
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    obs = {w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, ALUop, err};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  // Pop the whole expected sequence; inputs are scrambled after acceptance.
  task automatic drain(input bit hold);
    bit first = 1'b1;
    while (exp_q.size() > 0) begin
      check_cycle();
      if (first) begin
        s      = hold;
        opcode = 3'b111;
        op     = 2'($urandom_range(3));
        first  = 1'b0;
      end
    end
  endtask

  task automatic run(input logic [2:0] opc, input logic [1:0] o, input string name, input bit hold);
    s = 1'b1; opcode = opc; op = o;
    push_seq(opc, o, name);
    drain(hold);
  endtask

  // With the trap enabled: confirm acceptance is blocked, then clear by reset.
  task automatic trap_recover();
`ifdef ILLEGAL_TRAP_EN
    s = 1'b1; opcode = 3'b101; op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      push(idle(), "TRAP_BLOCK");
      check_cycle();
    end
    s = 1'b0;
    reset = 1'b1;
    err_model = 1'b0;
    push(idle(), "TRAP_RESET");
    check_cycle();
    reset = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push(idle(), "RESET");
    check_cycle();

    run(3'b101, 2'b00, "ADD",  1'b0);
    run(3'b101, 2'b10, "AND",  1'b0);
    run(3'b101, 2'b01, "CMP",  1'b0);
    run(3'b101, 2'b11, "MVN",  1'b0);
    run(3'b110, 2'b10, "MOVI", 1'b0);
    run(3'b110, 2'b00, "MOVR", 1'b0);

    // s held high: WAIT lasts exactly one cycle between the two ADDs.
    run(3'b101, 2'b00, "ADD_B2B1", 1'b1);
    run(3'b101, 2'b00, "ADD_B2B2", 1'b0);

    // Reset during GET_B of an ADD.
    s = 1'b1; opcode = 3'b101; op = 2'b00;
    push_seq(3'b101, 2'b00, "ADD_RST");
    check_cycle();
    s = 1'b0;
    check_cycle();
    check_cycle();
    reset = 1'b1;
    exp_q.delete();
    tag_q.delete();
    push(idle(), "RST_MID");
    check_cycle();
    reset = 1'b0;
    run(3'b101, 2'b11, "MVN_AFTER_RST", 1'b0);

    // Illegal instructions.
    run(3'b111, 2'b00, "ILL_111", 1'b0);
    trap_recover();
    run(3'b101, 2'b00, "ADD_AFTER_ILL", 1'b0);
    run(3'b110, 2'b01, "ILL_MOV01", 1'b0);
    trap_recover();
    run(3'b110, 2'b11, "ILL_MOV11", 1'b0);
    trap_recover();
    run(3'b000, 2'b10, "ILL_000", 1'b0);
    trap_recover();
    run(3'b110, 2'b10, "MOVI_END", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle Moore controller that sequences the register-file / shifter / ALU datapath for the ALU and MOV instruction classes. It accepts a decoded opcode/op pair via a start/wait handshake and steps through operand fetch, execute and writeback. Each step drives the datapath load, select and write strobes and the 2-bit ALUop. It sits between instruction decode and the datapath, one level above the ALU.

Parameters:
STATE_W, 4, width of internal state register (must hold 9 states)
ALUOP_W, 2, width of ALUop output (matches ALU encoding)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
s  input  1  start request; sampled only in WAIT
opcode  input  3  instruction class (110 = MOV, 101 = ALU)
op  input  2  sub-op / ALU operation select
w  output  1  ready/idle; 1 only in WAIT
nsel  output  3  one-hot regfile select: 001 Rn, 010 Rd, 100 Rm; 000 when idle
vsel  output  1  writeback source: 0 = datapath C, 1 = sign-extended imm8
loada  output  1  load A register
loadb  output  1  load B register
asel  output  1  1 = force A operand to zero
bsel  output  1  reserved; held 0
loadc  output  1  load C register
loads  output  1  load status (Z) register
write  output  1  regfile write enable
ALUop  output  ALUOP_W  00 add, 01 sub, 10 and, 11 not-B
err  output  1  illegal-instruction flag (see Optional Feature)

Behaviour:
- States: WAIT, DECODE, GET_A, GET_B, EXEC, EXEC_S, WR_REG, WR_IMM, ILL.
- All outputs are a pure function of the registered state plus the latched op. No combinational path from s/opcode/op to outputs.
- Reset: state <= WAIT; w=1, nsel=000, every strobe 0, ALUop=00, err=0.
- Handshake: in WAIT with s=1, latch opcode/op and go to DECODE. s is ignored in every other state. Inputs may change after acceptance.
- Transitions from DECODE (latched fields):
  - 110/10 MOV imm -> WR_IMM: nsel=001, vsel=1, write=1 -> WAIT.
  - 110/00 MOV reg -> GET_B -> EXEC (asel=1, ALUop=00) -> WR_REG.
  - 101/00 ADD and 101/10 AND -> GET_A -> GET_B -> EXEC -> WR_REG.
  - 101/01 CMP -> GET_A -> GET_B -> EXEC_S -> WAIT.
  - 101/11 MVN -> GET_B -> EXEC -> WR_REG.
  - Any other opcode/op combination -> ILL -> WAIT.
- Per-state strobes:
  - GET_A: nsel=001, loada=1.
  - GET_B: nsel=100, loadb=1.
  - EXEC: loadc=1, ALUop=latched op (00 for MOV reg).
  - EXEC_S: loads=1, ALUop=01, loadc=0.
  - WR_REG: nsel=010, vsel=0, write=1.
- Latency from the accepting edge to w=1: ADD/AND 5 cycles, CMP 4, MVN 4, MOV reg 4, MOV imm 2, illegal 2.
- At most one of loada/loadb/loadc/loads/write is high in any cycle.
- Back-to-back: s held high re-accepts on the first WAIT cycle, so w is high for exactly one cycle.
- Reset mid-operation: next state is WAIT regardless of current state. No write strobe in the cycle after the reset edge.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined: entering ILL sets err. err is sticky and blocks acceptance (w=0 while in WAIT) until reset.
- Undefined: err is tied 0, ILL passes straight to WAIT, and the controller stays usable.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - state enum;
  - opcode constants OPC_MOV=3'b110, OPC_ALU=3'b101;
  - ALUop constants ALU_ADD/SUB/AND/NOT;
  - nsel one-hot constants NSEL_RN/RD/RM.
- One sub-module, alu_seq_decode: combinational state-to-strobe table, isolated for reuse by the later memory-op controller.

Test Plan:
- ADD (101/00), s=1 one cycle -> loada at cycle 2, loadb at 3, loadc with ALUop=00 at 4, write with nsel=010 at 5, w=1 at 6.
- CMP (101/01) -> loads=1 with ALUop=01 at cycle 4; write never asserted; w=1 at cycle 5.
- MOV imm (110/10) -> write=1, vsel=1, nsel=001 at cycle 2; w=1 at 3. Then MOV reg (110/00) -> asel=1 during EXEC.
- Illegal opcode 111/00 -> no strobes asserted, w returns at cycle 3. With ILLEGAL_TRAP_EN: err=1 and a following s=1 is not accepted until reset.
- reset pulsed during GET_B of ADD -> next cycle state WAIT, w=1, write stays 0; following MVN (101/11) completes with ALUop=11.
- s held high across two ADDs -> w high exactly one cycle between them; opcode changed mid-op has no effect on the sequence.
